// File: rtl/aib_link_bringup_seq_if.sv
// Bundle between the AIB bring-up sequencer and its environment: status inputs
// from the AIB wrapper, per-channel control back to it, and link status.
interface aib_link_bringup_seq_if #(
    parameter int NBR_CHNLS = 24
);
    logic                 start;
    logic                 m_device_detect;
    logic [NBR_CHNLS-1:0] fs_mac_rdy;
    logic [NBR_CHNLS-1:0] m_rx_align_done;
    logic [NBR_CHNLS-1:0] ns_adapter_rstn;
    logic [NBR_CHNLS-1:0] ns_mac_rdy;
    logic [NBR_CHNLS-1:0] ms_rx_dcc_dll_lock_req;
    logic [NBR_CHNLS-1:0] ms_tx_dcc_dll_lock_req;
    logic [NBR_CHNLS-1:0] sl_rx_dcc_dll_lock_req;
    logic [NBR_CHNLS-1:0] sl_tx_dcc_dll_lock_req;
    logic                 axi_en;
    logic                 link_up;
    logic                 link_err;
    logic [2:0]           err_code;
    logic [2:0]           state;

    modport master (
        output start, m_device_detect, fs_mac_rdy, m_rx_align_done,
        input  ns_adapter_rstn, ns_mac_rdy,
               ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req,
               sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
               axi_en, link_up, link_err, err_code, state
    );

    modport slave (
        input  start, m_device_detect, fs_mac_rdy, m_rx_align_done,
        output ns_adapter_rstn, ns_mac_rdy,
               ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req,
               sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
               axi_en, link_up, link_err, err_code, state
    );
endinterface

// File: rtl/aib_link_bringup_seq.sv
// Leader-side AIB link bring-up sequencer: orders adapter reset, DCC/DLL lock and
// MAC-ready, waits for far-side readiness and alignment, then gates AXI traffic on.
module aib_link_bringup_seq #(
    parameter int NBR_CHNLS    = 24,
    parameter int ACTIVE_CHNLS = 24,
    parameter int RST_HOLD     = 32,
    parameter int DLL_WAIT     = 64,
    parameter int TIMEOUT      = 65535
) (
    input logic clk_wr,
    input logic rst_wr,
    aib_link_bringup_seq_if.slave link
);

    localparam int MAX_A = (RST_HOLD > DLL_WAIT) ? RST_HOLD : DLL_WAIT;
    localparam int MAX_V = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int TW    = $clog2(MAX_V + 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_DETECT = 3'd1,
        RST_REL     = 3'd2,
        DLL_REQ     = 3'd3,
        WAIT_MAC    = 3'd4,
        WAIT_ALIGN  = 3'd5,
        LINK_UP     = 3'd6,
        ERROR       = 3'd7
    } state_t;

    function automatic logic [NBR_CHNLS-1:0] active_mask();
        logic [NBR_CHNLS-1:0] m;
        for (int i = 0; i < NBR_CHNLS; i++) m[i] = (i < ACTIVE_CHNLS);
        return m;
    endfunction

    localparam logic [NBR_CHNLS-1:0] MASK = active_mask();

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == {TW{1'b1}}) ? t : t + 1'b1;
    endfunction

    // True on the cycle whose closing edge completes `limit` cycles in the state.
    function automatic logic hit(input logic [TW-1:0] t, input int limit);
        return (int'(t) + 1) >= limit;
    endfunction

    state_t               state_q, state_d;
    logic [TW-1:0]        timer;
    logic [2:0]           err_q, err_d;
    logic                 det_p0, det_p1;
    logic [NBR_CHNLS-1:0] mac_p0, mac_p1, aln_p0, aln_p1;
    logic                 mac_ok, aln_ok;

    logic [NBR_CHNLS-1:0] rstn_d, mrdy_d, lock_d;
    logic                 axi_d, lu_d, lerr_d;
    logic [NBR_CHNLS-1:0] rstn_q, mrdy_q, lock_q;
    logic                 axi_q, lu_q, lerr_q;

    // Two-flop synchronizers: _p0 first stage, _p1 is what the FSM sees
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            det_p0 <= 1'b0;
            det_p1 <= 1'b0;
            mac_p0 <= '0;
            mac_p1 <= '0;
            aln_p0 <= '0;
            aln_p1 <= '0;
        end else begin
            det_p0 <= link.m_device_detect;
            det_p1 <= det_p0;
            mac_p0 <= link.fs_mac_rdy;
            mac_p1 <= mac_p0;
            aln_p0 <= link.m_rx_align_done;
            aln_p1 <= aln_p0;
        end
    end

    assign mac_ok = ((mac_p1 & MASK) == MASK);
    assign aln_ok = ((aln_p1 & MASK) == MASK);

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state_q <= IDLE;
            timer   <= '0;
            err_q   <= 3'd0;
            rstn_q  <= '0;
            mrdy_q  <= '0;
            lock_q  <= '0;
            axi_q   <= 1'b0;
            lu_q    <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer   <= (state_d != state_q) ? '0 : sat_inc(timer);
            err_q   <= err_d;
            rstn_q  <= rstn_d;
            mrdy_q  <= mrdy_d;
            lock_q  <= lock_d;
            axi_q   <= axi_d;
            lu_q    <= lu_d;
            lerr_q  <= lerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (link.start) begin
                state_d = WAIT_DETECT;
                err_d   = 3'd0;
            end
        end else if (!link.start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                WAIT_DETECT: begin
                    if (det_p1) state_d = RST_REL;
                    else if (hit(timer, TIMEOUT)) begin
                        state_d = ERROR;
                        err_d   = 3'd1;
                    end
                end
                RST_REL:  if (hit(timer, RST_HOLD)) state_d = DLL_REQ;
                DLL_REQ:  if (hit(timer, DLL_WAIT)) state_d = WAIT_MAC;
                WAIT_MAC: begin
                    if (mac_ok) state_d = WAIT_ALIGN;
                    else if (hit(timer, TIMEOUT)) begin
                        state_d = ERROR;
                        err_d   = 3'd2;
                    end
                end
                WAIT_ALIGN: begin
                    if (aln_ok) state_d = LINK_UP;
                    else if (hit(timer, TIMEOUT)) begin
                        state_d = ERROR;
                        err_d   = 3'd3;
                    end
                end
                LINK_UP: begin
                    if (!(mac_ok && aln_ok)) begin
                        state_d = ERROR;
                        err_d   = 3'd4;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as `state`
    always_comb begin
        rstn_d = '0;
        mrdy_d = '0;
        lock_d = '0;
        axi_d  = 1'b0;
        lu_d   = 1'b0;
        lerr_d = 1'b0;
        case (state_d)
            DLL_REQ: begin
                rstn_d = MASK;
                lock_d = MASK;
            end
            WAIT_MAC, WAIT_ALIGN: begin
                rstn_d = MASK;
                lock_d = MASK;
                mrdy_d = MASK;
            end
            LINK_UP: begin
                rstn_d = MASK;
                lock_d = MASK;
                mrdy_d = MASK;
                axi_d  = 1'b1;
                lu_d   = 1'b1;
            end
            ERROR:   lerr_d = 1'b1;
            default: lerr_d = 1'b0;
        endcase
    end

    assign link.ns_adapter_rstn        = rstn_q;
    assign link.ns_mac_rdy             = mrdy_q;
    assign link.ms_rx_dcc_dll_lock_req = lock_q;
    assign link.ms_tx_dcc_dll_lock_req = lock_q;
    assign link.sl_rx_dcc_dll_lock_req = lock_q;
    assign link.sl_tx_dcc_dll_lock_req = lock_q;
    assign link.axi_en                 = axi_q;
    assign link.link_up                = lu_q;
    assign link.link_err               = lerr_q;
    assign link.err_code               = err_q;
    assign link.state                  = state_q;

endmodule

// File: tb/tb_aib_link_bringup_seq.sv
// Directed bench for aib_link_bringup_seq: a vector table walks a full bring-up,
// link drop, restart and detect timeout; hand sequences cover the remaining corners.
module tb_aib_link_bringup_seq;
    localparam int N = 24;
    localparam logic [N-1:0] F = 24'h00000F;
    localparam logic [N-1:0] B = 24'h00000B;
    localparam logic [N-1:0] Z = 24'h000000;

    logic clk_wr = 1'b0;
    logic rst_wr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_wr = ~clk_wr;

    aib_link_bringup_seq_if #(.NBR_CHNLS(N)) link ();

    aib_link_bringup_seq #(
        .NBR_CHNLS(N), .ACTIVE_CHNLS(4), .RST_HOLD(8), .DLL_WAIT(16), .TIMEOUT(1000)
    ) dut (
        .clk_wr(clk_wr),
        .rst_wr(rst_wr),
        .link  (link.slave)
    );

    typedef struct {
        int           ncyc;
        logic         start;
        logic         det;
        logic [N-1:0] mac;
        logic [N-1:0] aln;
        logic [2:0]   st;
        logic [N-1:0] rstn;
        logic [N-1:0] mrdy;
        logic [N-1:0] lock;
        logic         axi;
        logic         lu;
        logic         err;
        logic [2:0]   code;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [N-1:0] rstn,
                             input logic [N-1:0] mrdy, input logic [N-1:0] lock, input logic axi,
                             input logic lu, input logic err, input logic [2:0] code);
        chk({tag, ".state"},    32'(link.state), 32'(st));
        chk({tag, ".rstn"},     32'(link.ns_adapter_rstn), 32'(rstn));
        chk({tag, ".mac_rdy"},  32'(link.ns_mac_rdy), 32'(mrdy));
        chk({tag, ".ms_rx"},    32'(link.ms_rx_dcc_dll_lock_req), 32'(lock));
        chk({tag, ".ms_tx"},    32'(link.ms_tx_dcc_dll_lock_req), 32'(lock));
        chk({tag, ".sl_rx"},    32'(link.sl_rx_dcc_dll_lock_req), 32'(lock));
        chk({tag, ".sl_tx"},    32'(link.sl_tx_dcc_dll_lock_req), 32'(lock));
        chk({tag, ".axi_en"},   32'(link.axi_en), 32'(axi));
        chk({tag, ".link_up"},  32'(link.link_up), 32'(lu));
        chk({tag, ".link_err"}, 32'(link.link_err), 32'(err));
        chk({tag, ".err_code"}, 32'(link.err_code), 32'(code));
    endtask

    task automatic go_idle();
        link.start           = 1'b0;
        link.m_device_detect = 1'b1;
        link.fs_mac_rdy      = Z;
        link.m_rx_align_done = Z;
        repeat (3) tick();
    endtask

    // From settled IDLE with detect high: ends right after WAIT_MAC entry
    task automatic goto_mac();
        link.start = 1'b1;
        tick();
        tick();
        repeat (8) tick();
        repeat (16) tick();
    endtask

    task automatic goto_align();
        goto_mac();
        link.fs_mac_rdy = F;
        repeat (3) tick();
    endtask

    initial begin
        // ncyc start det mac aln | state rstn mrdy lock axi lu err code
        tbl.push_back('{3,   1'b0, 1'b1, Z, Z, 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, Z, Z, 3'd1, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, Z, Z, 3'd2, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{7,   1'b1, 1'b1, Z, Z, 3'd2, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, Z, Z, 3'd3, F, Z, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{15,  1'b1, 1'b1, Z, Z, 3'd3, F, Z, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, Z, Z, 3'd4, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{19,  1'b1, 1'b1, Z, Z, 3'd4, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{2,   1'b1, 1'b1, F, Z, 3'd4, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, F, Z, 3'd5, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{7,   1'b1, 1'b1, F, Z, 3'd5, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{2,   1'b1, 1'b1, F, F, 3'd5, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, F, F, 3'd6, F, F, F, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{5,   1'b1, 1'b1, F, F, 3'd6, F, F, F, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{2,   1'b1, 1'b1, F, B, 3'd6, F, F, F, 1'b1, 1'b1, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, F, B, 3'd7, Z, Z, Z, 1'b0, 1'b0, 1'b1, 3'd4});
        tbl.push_back('{5,   1'b1, 1'b1, F, B, 3'd7, Z, Z, Z, 1'b0, 1'b0, 1'b1, 3'd4});
        tbl.push_back('{1,   1'b0, 1'b1, F, B, 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd4});
        tbl.push_back('{3,   1'b0, 1'b1, F, B, 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd4});
        tbl.push_back('{1,   1'b1, 1'b1, F, B, 3'd1, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b1, F, B, 3'd2, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{8,   1'b1, 1'b1, F, B, 3'd3, F, Z, F, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b0, 1'b1, F, B, 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{3,   1'b0, 1'b0, Z, Z, 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b0, Z, Z, 3'd1, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{999, 1'b1, 1'b0, Z, Z, 3'd1, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0});
        tbl.push_back('{1,   1'b1, 1'b0, Z, Z, 3'd7, Z, Z, Z, 1'b0, 1'b0, 1'b1, 3'd1});
        tbl.push_back('{1,   1'b0, 1'b0, Z, Z, 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd1});

        rst_wr               = 1'b1;
        link.start           = 1'b0;
        link.m_device_detect = 1'b1;
        link.fs_mac_rdy      = Z;
        link.m_rx_align_done = Z;
        #12;
        check_all("reset", 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0);
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            link.start           = tbl[i].start;
            link.m_device_detect = tbl[i].det;
            link.fs_mac_rdy      = tbl[i].mac;
            link.m_rx_align_done = tbl[i].aln;
            repeat (tbl[i].ncyc) tick();
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].rstn, tbl[i].mrdy, tbl[i].lock,
                      tbl[i].axi, tbl[i].lu, tbl[i].err, tbl[i].code);
        end

        // Asynchronous reset while waiting for alignment
        go_idle();
        goto_align();
        check_all("pre_rst", 3'd5, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0);
        rst_wr = 1'b1;
        #2;
        check_all("async_rst", 3'd0, Z, Z, Z, 1'b0, 1'b0, 1'b0, 3'd0);
        link.start = 1'b0;
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;

        // MAC timeout
        go_idle();
        goto_mac();
        repeat (999) tick();
        check_all("mac_wait", 3'd4, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        check_all("mac_to", 3'd7, Z, Z, Z, 1'b0, 1'b0, 1'b1, 3'd2);

        // Align timeout
        go_idle();
        goto_align();
        repeat (999) tick();
        check_all("aln_wait", 3'd5, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        check_all("aln_to", 3'd7, Z, Z, Z, 1'b0, 1'b0, 1'b1, 3'd3);

        // Align completes on the very edge the timeout would fire
        go_idle();
        goto_align();
        repeat (997) tick();
        link.m_rx_align_done = F;
        repeat (2) tick();
        check_all("race_pre", 3'd5, F, F, F, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        check_all("race_win", 3'd6, F, F, F, 1'b1, 1'b1, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aib_link_bringup_seq.md
# aib_link_bringup_seq

Leader-side AIB link bring-up sequencer placed directly upstream of `top_aib_axi_bridge_master_wrapper`. It drives the wrapper's per-channel adapter reset, MAC-ready and DCC/DLL lock-request inputs in a fixed order. It then waits for far-side MAC ready and RX alignment, and only then enables AXI traffic into the bridge. It also supervises the link: it detects timeouts and link drops and reports them with an error code.

## Interface
Parameters:
- `NBR_CHNLS`, 24, width of all per-channel vectors.
- `ACTIVE_CHNLS`, 24, number of active channels, always the LSBs. Range 1..NBR_CHNLS.
- `RST_HOLD`, 32, cycles spent in RST_REL before adapter reset is released. Must be ≥1.
- `DLL_WAIT`, 64, cycles spent in DLL_REQ before MAC-ready is asserted. Must be ≥1.
- `TIMEOUT`, 65535, maximum cycles allowed in each wait state. Must be ≥1.

Ports:
- `clk_wr`, in, 1, single clock for the whole block.
- `rst_wr`, in, 1, asynchronous active-high reset.
- `start`, in, 1, level enable, synchronous to `clk_wr`.
- `m_device_detect`, in, 1, from the wrapper. Asynchronous; synchronized internally.
- `fs_mac_rdy`, in, NBR_CHNLS, from the wrapper. Asynchronous; synchronized internally.
- `m_rx_align_done`, in, NBR_CHNLS, from the wrapper. Asynchronous; synchronized internally.
- `ns_adapter_rstn`, out, NBR_CHNLS, to the wrapper.
- `ns_mac_rdy`, out, NBR_CHNLS, to the wrapper.
- `ms_rx_dcc_dll_lock_req`, `ms_tx_dcc_dll_lock_req`, `sl_rx_dcc_dll_lock_req`, `sl_tx_dcc_dll_lock_req`, out, NBR_CHNLS each. All four are driven identically.
- `axi_en`, out, 1, gate for AXI valid signals into the bridge.
- `link_up`, out, 1, link is up.
- `link_err`, out, 1, sticky error flag.
- `err_code`, out, 3, error cause. 0 none, 1 detect timeout, 2 MAC timeout, 3 align timeout, 4 link drop.
- `state`, out, 3, current FSM state encoding.

## Operation
Active mask: bits [ACTIVE_CHNLS-1:0] are 1. Inactive channel outputs are always 0, and inactive channel inputs are ignored.

Input synchronization: `m_device_detect`, `fs_mac_rdy` and `m_rx_align_done` each pass through a 2-flop synchronizer. The FSM uses only the synchronized values.

Timer: a single counter of width clog2(max(RST_HOLD,DLL_WAIT,TIMEOUT)+1). It clears on every state change, increments every cycle otherwise, and saturates.

States:
- IDLE=0: all outputs 0; `err_code` retains its last value. `start`=1 → WAIT_DETECT, and `err_code` clears to 0.
- WAIT_DETECT=1: synchronized detect=1 → RST_REL. Timer reaching TIMEOUT → ERROR with code 1.
- RST_REL=2: `ns_adapter_rstn`=0. Timer reaching RST_HOLD → DLL_REQ.
- DLL_REQ=3: `ns_adapter_rstn` and all four lock requests are set to the mask. Timer reaching DLL_WAIT → WAIT_MAC.
- WAIT_MAC=4: `ns_mac_rdy` is also set to the mask. All active synchronized `fs_mac_rdy`=1 → WAIT_ALIGN. Timeout → ERROR with code 2.
- WAIT_ALIGN=5: all active synchronized `m_rx_align_done`=1 → LINK_UP. Timeout → ERROR with code 3.
- LINK_UP=6: `link_up`=1, `axi_en`=1, and channel outputs are held. Any active synchronized `fs_mac_rdy` or `m_rx_align_done` dropping to 0 → ERROR with code 4.
- ERROR=7: all channel outputs are 0, `axi_en`=0, `link_up`=0, `link_err`=1, and `err_code` is held.
- In every non-IDLE state, `start`=0 → IDLE. This has priority over all other transitions, including timeout and success.
- Simultaneous success and timeout in the same cycle: success wins.

## Timing
- Reset: all outputs 0, `state`=IDLE, timer 0, synchronizers 0. Reset asserted mid-sequence forces these values immediately, asynchronously. Release takes effect on the first rising edge after deassertion.
- All outputs are registered decodes of the next state, so they change on the same edge on which `state` changes.
- `start` rises before edge E: the state is WAIT_DETECT after E.
- Input latency: an input change between edges k-1 and k causes the state transition at edge k+2.
- RST_REL is entered at edge E and exits at edge E+RST_HOLD; `ns_adapter_rstn` rises on that exit edge.
- DLL_REQ behaves the same way with DLL_WAIT; `ns_mac_rdy` rises on its exit edge.
- A timeout fires on the edge on which the timer would reach TIMEOUT, i.e. exactly TIMEOUT cycles after entering the wait state.
- `axi_en` falls on the same edge that leaves LINK_UP.

## Test plan
- Nominal bring-up, with NBR_CHNLS=24, ACTIVE_CHNLS=4, RST_HOLD=8, DLL_WAIT=16, TIMEOUT=1000. Detect is high at start; the far side raises `fs_mac_rdy`[3:0] 20 cycles after `ns_mac_rdy`, and align 10 cycles later.
  - Required: `ns_adapter_rstn`=0x00000F exactly 8 cycles after RST_REL entry.
  - Required: `ns_mac_rdy`=0x00000F 16 cycles later.
  - Required: `link_up`=`axi_en`=1 three edges after the last align bit rises, with `err_code`=0.
- Detect held at 0 → ERROR exactly 1000 cycles after WAIT_DETECT entry, with `link_err`=1, `err_code`=1 and all outputs 0.
- In LINK_UP, drop `m_rx_align_done`[2] → ERROR on the third edge, `err_code`=4 and `axi_en`=0. Then `start`=0 → IDLE, and `err_code` stays at 4 until the next `start` clears it.
- Hold `fs_mac_rdy`[23:4]=0 and `fs_mac_rdy`[3:0]=1 → LINK_UP is reached; inactive channel outputs stay 0 throughout.
- Deassert `start` in DLL_REQ → IDLE on the next edge with all outputs 0. Separately, pulse `rst_wr` in WAIT_ALIGN → outputs go to 0 asynchronously, before the next clock edge.
- Make align complete on the same edge that the timer hits TIMEOUT → LINK_UP, not ERROR.
